// File: rtl/combine_alu.sv
// Multi-cycle add/sub/mul/div stage for the card game FSM.
// Division is a W-step restoring divider; results are range-checked for W-bit unsigned values.
module combine_alu #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err,
  output logic [1:0]   err_code
);

  localparam int unsigned CntW = $clog2(W);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpDiv = 2'b11;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrDivZero = 2'b01;
  localparam logic [1:0] ErrInexact = 2'b10;
  localparam logic [1:0] ErrRange   = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StDiv, StDone} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [W-1:0]      rem_q, rem_d, quo_q, quo_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]      result_q, result_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [W:0]        sum;
  logic [2*W-1:0]    prod;
  logic [W:0]        shifted, trial;
  logic              trial_ok;

  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    prod     = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    shifted  = {rem_q, quo_q[W-1]};
    trial    = shifted - {1'b0, b_q};
    // Remainder stays below b, so a set top bit can only mean the trial went negative.
    trial_ok = ~trial[W];

    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    err_code_d = err_code_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StDone;
        unique case (op_q)
          OpAdd: begin
            err_code_d = sum[W] ? ErrRange : ErrNone;
            result_d   = sum[W] ? '0 : sum[W-1:0];
          end
          OpSub: begin
            err_code_d = (a_q < b_q) ? ErrRange : ErrNone;
            result_d   = (a_q < b_q) ? '0 : a_q - b_q;
          end
          OpMul: begin
            err_code_d = (|prod[2*W-1:W]) ? ErrRange : ErrNone;
            result_d   = (|prod[2*W-1:W]) ? '0 : prod[W-1:0];
          end
          OpDiv: begin
            if (b_q == '0) begin
              err_code_d = ErrDivZero;
              result_d   = '0;
            end else begin
              quo_d   = a_q;
              rem_d   = '0;
              cnt_d   = CntW'(W - 1);
              state_d = StDiv;
            end
          end
        endcase
      end
      StDiv: begin
        rem_d = trial_ok ? trial[W-1:0] : shifted[W-1:0];
        quo_d = {quo_q[W-2:0], trial_ok};
        if (cnt_q == '0) begin
          state_d    = StDone;
          err_code_d = (rem_d != '0) ? ErrInexact : ErrNone;
          result_d   = (rem_d != '0) ? '0 : quo_d;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      err_code_q <= err_code_d;
    end
  end

  assign busy     = (state_q == StExec) || (state_q == StDiv);
  assign done     = (state_q == StDone);
  assign result   = result_q;
  assign err_code = err_code_q;
  assign err      = (err_code_q != ErrNone);

endmodule

// File: tb/tb_combine_alu.sv
// Directed bench for combine_alu: latency, results, error codes, ignored starts and reset abort.
module tb_combine_alu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] a = '0;
  logic [9:0] b = '0;
  logic [1:0] op = '0;
  logic       busy, done, err;
  logic [9:0] result;
  logic [1:0] err_code;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  combine_alu #(.W(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .op       (op),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .err      (err),
    .err_code (err_code)
  );

  // Issues one operation from IDLE; edges counts the start-sampling edge as edge 1 (-1 on timeout).
  task automatic run_op(input logic [9:0] ia, input logic [9:0] ib, input logic [1:0] iop,
                        input bit scramble, output int edges, output int bcyc,
                        output logic [9:0] res, output logic [1:0] code, output logic e);
    bit seen = 0;
    @(negedge clk);
    a = ia; b = ib; op = iop; start = 1'b1;
    edges = 0; bcyc = 0; res = 'x; code = 'x; e = 1'bx;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
      if (scramble) begin
        a = 10'(edges * 37); b = '0; op = 2'(edges);
      end
      if (busy) bcyc++;
      if (done) begin
        seen = 1; res = result; code = err_code; e = err;
      end
    end
    if (!seen) edges = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (result !== 10'd0) begin bad++; $display("FAIL reset_result: got %0d want 0", result); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++; if (err_code !== 2'b00) begin bad++; $display("FAIL reset_code: got %b want 00", err_code); end
    rst = 1'b0;
  endtask

  task automatic test_add_mul();
    int ed, bc; logic [9:0] r; logic [1:0] c; logic e;
    run_op(10'd6, 10'd4, 2'b10, 0, ed, bc, r, c, e);
    total++; if (ed !== 2) begin bad++; $display("FAIL mul_latency: got %0d want 2", ed); end
    total++; if (r !== 10'd24) begin bad++; $display("FAIL mul_result: got %0d want 24", r); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL mul_err: got %b want 0", e); end
    run_op(10'd20, 10'd4, 2'b00, 0, ed, bc, r, c, e);
    total++; if (r !== 10'd24) begin bad++; $display("FAIL add_result: got %0d want 24", r); end
    total++; if (bc !== 1) begin bad++; $display("FAIL add_busy_cycles: got %0d want 1", bc); end
    total++; if (ed !== 2) begin bad++; $display("FAIL add_latency: got %0d want 2", ed); end
  endtask

  task automatic test_div();
    int ed, bc; logic [9:0] r; logic [1:0] c; logic e;
    run_op(10'd72, 10'd3, 2'b11, 0, ed, bc, r, c, e);
    total++; if (ed !== 12) begin bad++; $display("FAIL div_latency: got %0d want 12", ed); end
    total++; if (bc !== 11) begin bad++; $display("FAIL div_busy_cycles: got %0d want 11", bc); end
    total++; if (r !== 10'd24) begin bad++; $display("FAIL div_result: got %0d want 24", r); end
    total++; if (c !== 2'b00) begin bad++; $display("FAIL div_code: got %b want 00", c); end
    run_op(10'd0, 10'd7, 2'b11, 0, ed, bc, r, c, e);
    total++; if (r !== 10'd0) begin bad++; $display("FAIL div_zero_num_result: got %0d want 0", r); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL div_zero_num_err: got %b want 0", e); end
    run_op(10'd1000, 10'd8, 2'b11, 0, ed, bc, r, c, e);
    total++; if (r !== 10'd125) begin bad++; $display("FAIL div_1000_8: got %0d want 125", r); end
  endtask

  task automatic test_errors();
    int ed, bc; logic [9:0] r; logic [1:0] c; logic e;
    run_op(10'd8, 10'd3, 2'b11, 0, ed, bc, r, c, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL inexact_err: got %b want 1", e); end
    total++; if (c !== 2'b10) begin bad++; $display("FAIL inexact_code: got %b want 10", c); end
    total++; if (r !== 10'd0) begin bad++; $display("FAIL inexact_result: got %0d want 0", r); end
    total++; if (ed !== 12) begin bad++; $display("FAIL inexact_latency: got %0d want 12", ed); end
    run_op(10'd24, 10'd0, 2'b11, 0, ed, bc, r, c, e);
    total++; if (c !== 2'b01) begin bad++; $display("FAIL divzero_code: got %b want 01", c); end
    total++; if (ed !== 2) begin bad++; $display("FAIL divzero_latency: got %0d want 2", ed); end
    total++; if (r !== 10'd0) begin bad++; $display("FAIL divzero_result: got %0d want 0", r); end
  endtask

  task automatic test_range();
    int ed, bc; logic [9:0] r; logic [1:0] c; logic e;
    run_op(10'd3, 10'd8, 2'b01, 0, ed, bc, r, c, e);
    total++; if (c !== 2'b11 || r !== 10'd0 || e !== 1'b1) begin bad++;
      $display("FAIL sub_range: got code=%b res=%0d err=%b want 11/0/1", c, r, e); end
    run_op(10'd1023, 10'd1, 2'b00, 0, ed, bc, r, c, e);
    total++; if (c !== 2'b11 || r !== 10'd0) begin bad++;
      $display("FAIL add_range: got code=%b res=%0d want 11/0", c, r); end
    run_op(10'd32, 10'd32, 2'b10, 0, ed, bc, r, c, e);
    total++; if (c !== 2'b11 || r !== 10'd0) begin bad++;
      $display("FAIL mul_range: got code=%b res=%0d want 11/0", c, r); end
  endtask

  task automatic test_boundaries();
    int ed, bc; logic [9:0] r; logic [1:0] c; logic e;
    run_op(10'd5, 10'd5, 2'b01, 0, ed, bc, r, c, e);
    total++; if (r !== 10'd0 || c !== 2'b00) begin bad++;
      $display("FAIL sub_equal: got res=%0d code=%b want 0/00", r, c); end
    run_op(10'd1023, 10'd0, 2'b00, 0, ed, bc, r, c, e);
    total++; if (r !== 10'd1023 || c !== 2'b00) begin bad++;
      $display("FAIL add_max: got res=%0d code=%b want 1023/00", r, c); end
    run_op(10'd1023, 10'd1, 2'b10, 0, ed, bc, r, c, e);
    total++; if (r !== 10'd1023 || c !== 2'b00) begin bad++;
      $display("FAIL mul_max: got res=%0d code=%b want 1023/00", r, c); end
    run_op(10'd100, 10'd37, 2'b01, 0, ed, bc, r, c, e);
    total++; if (r !== 10'd63) begin bad++; $display("FAIL sub_100_37: got %0d want 63", r); end
  endtask

  // Start held high: ops complete on edges 2,5,8,11 and DONE is never two cycles long.
  task automatic test_back_to_back();
    int dones = 0; int dbl = 0; logic prev = 1'b0;
    @(negedge clk);
    a = 10'd5; b = 10'd3; op = 2'b00; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (done && prev) dbl++;
      prev = done;
    end
    start = 1'b0;
    total++; if (dones !== 4) begin bad++; $display("FAIL hold_start_dones: got %0d want 4", dones); end
    total++; if (dbl !== 0) begin bad++; $display("FAIL hold_start_long_done: got %0d want 0", dbl); end
    total++; if (result !== 10'd8) begin bad++; $display("FAIL hold_start_result: got %0d want 8", result); end
  endtask

  task automatic test_held_operands();
    int ed, bc; logic [9:0] r; logic [1:0] c; logic e;
    run_op(10'd72, 10'd3, 2'b11, 1, ed, bc, r, c, e);
    total++; if (r !== 10'd24 || c !== 2'b00) begin bad++;
      $display("FAIL scrambled_inputs: got res=%0d code=%b want 24/00", r, c); end
    total++; if (ed !== 12) begin bad++; $display("FAIL scrambled_latency: got %0d want 12", ed); end
  endtask

  task automatic test_reset_mid_div();
    int ed, bc; logic [9:0] r; logic [1:0] c; logic e;
    bit saw = 0;
    @(negedge clk);
    a = 10'd72; b = 10'd3; op = 2'b11; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) saw = 1;
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL middiv_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL middiv_busy: got %b want 0", busy); end
    total++; if (result !== 10'd0 || err !== 1'b0) begin bad++;
      $display("FAIL middiv_outputs: got res=%0d err=%b want 0/0", result, err); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) saw = 1;
    end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL middiv_done_pulse: got %b want 0", saw); end
    run_op(10'd12, 10'd2, 2'b00, 0, ed, bc, r, c, e);
    total++; if (r !== 10'd14 || ed !== 2) begin bad++;
      $display("FAIL after_reset_add: got res=%0d edges=%0d want 14/2", r, ed); end
  endtask

  initial begin
    test_reset();
    test_add_mul();
    test_div();
    test_errors();
    test_range();
    test_boundaries();
    test_back_to_back();
    test_held_operands();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
